// File: rtl/sd_card_host_bridge.sv
// CPU register bridge to an SD card controller with a 512-byte sector buffer.
// Handshake: a CPU access is a single-cycle i_cpu_sel strobe. o_cpu_ready pulses exactly
// one cycle later, and o_cpu_rdata is valid only during that pulse. Neither side can
// apply back-pressure. On the SD side, i_sd_req qualifies each buffer access for one
// cycle. i_sd_write_statusreg is a one-cycle completion pulse from the controller.
module sd_card_host_bridge #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_sel,
    input  logic        i_cpu_we,
    input  logic [1:0]  i_cpu_reg,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ready,
    output logic        o_irq,
    output logic [7:0]  o_sd_controlreg,
    output logic [31:0] o_sd_addr,
    output logic [7:0]  o_sd_data,
    input  logic [7:0]  i_sd_statusreg,
    input  logic        i_sd_write_statusreg,
    input  logic [7:0]  i_sd_data,
    input  logic [31:0] i_sd_addr,
    input  logic        i_sd_wr_nrd,
    input  logic        i_sd_req,
    input  logic [7:0]  i_sd_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q;
    logic [31:0] sector_q;
    logic [8:0]  ptr_q;
    logic [7:0]  last_status_q;
    logic        done_q, err_busy_q, timeout_q;
    logic [23:0] tmo_cnt_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic [7:0]  sd_data_q;
    logic [7:0]  sector_buf [0:511];

    logic        busy, cpu_wr, cpu_rd, ctrl_wr, cmd_valid, start_cmd, reject_cmd;
    logic        sd_done, tmo_hit, drain_done;
    logic [31:0] status_word, cpu_rd_val;
    logic [22:0] unused_sd_addr_hi;

    // Only the low 9 bits of the controller's byte index address the buffer.
    assign unused_sd_addr_hi = i_sd_addr[31:9];

    assign busy        = (state_q != ST_IDLE);
    assign cpu_wr      = i_cpu_sel & i_cpu_we;
    assign cpu_rd      = i_cpu_sel & ~i_cpu_we;
    assign ctrl_wr     = cpu_wr && (i_cpu_reg == 2'd0);
    assign cmd_valid   = (i_cpu_wdata[1:0] == 2'd1) || (i_cpu_wdata[1:0] == 2'd2);
    assign start_cmd   = ctrl_wr && cmd_valid && !busy;
    assign reject_cmd  = ctrl_wr && cmd_valid && busy;
    assign sd_done     = (state_q == ST_WAIT_DONE) && i_sd_write_statusreg;
    assign tmo_hit     = (state_q == ST_WAIT_DONE) && !i_sd_write_statusreg &&
                         (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);
    assign drain_done  = (state_q == ST_DRAIN) && (i_sd_state == 8'h01);
    assign status_word = {16'd0, last_status_q, 4'd0, timeout_q, err_busy_q, done_q, busy};

    // Drive the command only while it is outstanding, so a reset or completion withdraws it at once.
    assign o_sd_controlreg = ((state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE)) ? {6'd0, cmd_q} : 8'd0;
    assign o_sd_addr       = sector_q;
    assign o_sd_data       = sd_data_q;
    assign o_cpu_rdata     = rdata_q;
    assign o_cpu_ready     = ready_q;
    assign o_irq           = done_q | err_busy_q | timeout_q;

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_cmd) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (sd_done || tmo_hit) state_d = ST_DRAIN;
            ST_DRAIN:     if (drain_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // CPU read mux; the buffer and pointer are hidden from the CPU while an operation owns them.
    always_comb begin
        cpu_rd_val = 32'd0;
        case (i_cpu_reg)
            2'd0:    cpu_rd_val = status_word;
            2'd1:    cpu_rd_val = sector_q;
            2'd2:    cpu_rd_val = busy ? 32'd0 : {23'd0, ptr_q};
            default: cpu_rd_val = busy ? 32'd0 : {24'd0, sector_buf[ptr_q]};
        endcase
    end

    // Control/status registers, timeout counter and CPU response.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cmd_q         <= 2'd0;
            sector_q      <= 32'd0;
            ptr_q         <= 9'd0;
            last_status_q <= 8'd0;
            done_q        <= 1'b0;
            err_busy_q    <= 1'b0;
            timeout_q     <= 1'b0;
            tmo_cnt_q     <= 24'd0;
            rdata_q       <= 32'd0;
            ready_q       <= 1'b0;
            sd_data_q     <= 8'd0;
        end else begin
            ready_q   <= i_cpu_sel;
            rdata_q   <= cpu_rd ? cpu_rd_val : 32'd0;
            sd_data_q <= sector_buf[i_sd_addr[8:0]];
            if (start_cmd) cmd_q <= i_cpu_wdata[1:0];
            if (state_q == ST_ISSUE)          tmo_cnt_q <= 24'd0;
            else if (state_q == ST_WAIT_DONE) tmo_cnt_q <= tmo_cnt_q + 24'd1;
            if (sd_done) last_status_q <= i_sd_statusreg;
            // Clear first; a set event in the same cycle wins.
            if (ctrl_wr && i_cpu_wdata[8]) begin
                done_q     <= 1'b0;
                err_busy_q <= 1'b0;
                timeout_q  <= 1'b0;
            end
            if (reject_cmd) err_busy_q <= 1'b1;
            if (tmo_hit)    timeout_q  <= 1'b1;
            if (drain_done) done_q     <= 1'b1;
            if (cpu_wr && (i_cpu_reg == 2'd1) && !busy) sector_q <= i_cpu_wdata;
            if (i_cpu_sel && !busy) begin
                if (i_cpu_we && (i_cpu_reg == 2'd2)) ptr_q <= i_cpu_wdata[8:0];
                else if (i_cpu_reg == 2'd3)          ptr_q <= ptr_q + 9'd1;
            end
        end
    end

    // Sector buffer writes: the controller owns it while busy, the CPU while idle.
    always_ff @(posedge i_clk) begin
        if (busy && i_sd_req && i_sd_wr_nrd)
            sector_buf[i_sd_addr[8:0]] <= i_sd_data;
        else if (!busy && cpu_wr && (i_cpu_reg == 2'd3))
            sector_buf[ptr_q] <= i_cpu_wdata[7:0];
    end

endmodule

// File: tb/tb_sd_card_host_bridge.sv
// Bench for sd_card_host_bridge: reset values, register table, SD read/write transfers,
// drain, busy rejection, pointer wrap, random register traffic and timeout/reset.
module tb_sd_card_host_bridge;

  localparam logic [23:0] TMO_LONG  = 24'd4096;
  localparam logic [23:0] TMO_SHORT = 24'd16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_sel, cpu_we;
  logic [1:0]  cpu_reg;
  logic [31:0] cpu_wdata;
  logic [7:0]  sd_status, sd_data_in, sd_state_in;
  logic        sd_wstat, sd_wr_nrd, sd_req;
  logic [31:0] sd_addr_in;

  logic [31:0] rdata_l, rdata_t, sdaddr_l, sdaddr_t;
  logic        ready_l, ready_t, irq_l, irq_t;
  logic [7:0]  ctrl_l, ctrl_t, sddata_l, sddata_t;

  sd_card_host_bridge #(.TIMEOUT_CYCLES(TMO_LONG)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_reg(cpu_reg), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(rdata_l),
    .o_cpu_ready(ready_l), .o_irq(irq_l), .o_sd_controlreg(ctrl_l),
    .o_sd_addr(sdaddr_l), .o_sd_data(sddata_l), .i_sd_statusreg(sd_status),
    .i_sd_write_statusreg(sd_wstat), .i_sd_data(sd_data_in), .i_sd_addr(sd_addr_in),
    .i_sd_wr_nrd(sd_wr_nrd), .i_sd_req(sd_req), .i_sd_state(sd_state_in)
  );

  sd_card_host_bridge #(.TIMEOUT_CYCLES(TMO_SHORT)) u_dut_t (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_reg(cpu_reg), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(rdata_t),
    .o_cpu_ready(ready_t), .o_irq(irq_t), .o_sd_controlreg(ctrl_t),
    .o_sd_addr(sdaddr_t), .o_sd_data(sddata_t), .i_sd_statusreg(sd_status),
    .i_sd_write_statusreg(sd_wstat), .i_sd_data(sd_data_in), .i_sd_addr(sd_addr_in),
    .i_sd_wr_nrd(sd_wr_nrd), .i_sd_req(sd_req), .i_sd_state(sd_state_in)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_buf [512];
  logic [31:0] m_sector;
  logic [8:0]  m_ptr;
  logic [7:0]  m_last;
  logic [31:0] rv, r, e;

  typedef struct {
    logic        we;
    logic [1:0]  rsel;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_acc(input logic we, input logic [1:0] rsel, input logic [31:0] wd,
                         input bit use_t, output logic [31:0] rd);
    cpu_sel = 1'b1; cpu_we = we; cpu_reg = rsel; cpu_wdata = wd;
    @(negedge clk);
    cpu_sel = 1'b0; cpu_we = 1'b0;
    check("cpu_ready", {31'd0, use_t ? ready_t : ready_l}, 32'd1);
    rd = use_t ? rdata_t : rdata_l;
  endtask

  task automatic cpu_wr(input logic [1:0] rsel, input logic [31:0] wd);
    logic [31:0] dummy;
    cpu_acc(1'b1, rsel, wd, 1'b0, dummy);
  endtask

  task automatic cpu_rd(input logic [1:0] rsel, output logic [31:0] rd);
    cpu_acc(1'b0, rsel, 32'd0, 1'b0, rd);
  endtask

  task automatic pulse_done(input logic [7:0] st);
    sd_status = st; sd_wstat = 1'b1;
    tick(1);
    sd_wstat = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(3);
    check("rst_ctrl", {24'd0, ctrl_l}, 32'd0);
    check("rst_ctrl_t", {24'd0, ctrl_t}, 32'd0);
    check("rst_irq", {31'd0, irq_l}, 32'd0);
    check("rst_ready", {31'd0, ready_l}, 32'd0);
    check("rst_rdata", rdata_l, 32'd0);
    check("rst_sd_data", {24'd0, sddata_l}, 32'd0);
    check("rst_sd_addr", sdaddr_l, 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_reg = 2'd0; cpu_wdata = 32'd0;
    sd_status = 8'd0; sd_wstat = 1'b0; sd_data_in = 8'd0; sd_addr_in = 32'd0;
    sd_wr_nrd = 1'b0; sd_req = 1'b0; sd_state_in = 8'h01;
    @(negedge clk);
    apply_reset();

    // Register table, idle: {we, reg, wdata, check rdata, expected rdata}
    vecs[0]  = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,         1'b1, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 2'd1, 32'hDEADBEEF,  1'b0, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 32'h0,         1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 2'd2, 32'hFFFFFE05,  1'b0, 32'h0};
    vecs[6]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h5};
    vecs[7]  = '{1'b1, 2'd0, 32'h0,         1'b0, 32'h0};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b1, 2'd0, 32'hFFFFFEFF,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b1, 2'd3, 32'h12345677,  1'b0, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h6};
    vecs[13] = '{1'b1, 2'd2, 32'h5,         1'b0, 32'h0};
    vecs[14] = '{1'b0, 2'd3, 32'h0,         1'b1, 32'h77};
    vecs[15] = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h6};
    vecs[16] = '{1'b1, 2'd1, 32'h5,         1'b0, 32'h0};
    for (int i = 0; i < 17; i++) begin
      cpu_acc(vecs[i].we, vecs[i].rsel, vecs[i].wd, 1'b0, rv);
      if (vecs[i].chk) check($sformatf("vec%0d", i), rv, vecs[i].exp);
    end
    check("vec_irq_idle", {31'd0, irq_l}, 32'd0);

    // SD read: controller fills the buffer, then the CPU drains it through DATA.
    cpu_wr(2'd0, 32'h1);
    check("rd_issue_ctrl", {24'd0, ctrl_l}, 32'd1);
    check("rd_sd_addr", sdaddr_l, 32'd5);
    for (int i = 0; i < 512; i++) begin
      r = $urandom;
      sd_req = 1'b1; sd_wr_nrd = 1'b1; sd_addr_in = {r[31:9], 9'(i)}; sd_data_in = 8'(i);
      m_buf[i] = 8'(i);
      tick(1);
    end
    sd_req = 1'b0; sd_wr_nrd = 1'b0;
    check("rd_ctrl_held", {24'd0, ctrl_l}, 32'd1);
    pulse_done(8'h00);
    check("rd_ctrl_drop", {24'd0, ctrl_l}, 32'd0);
    check("rd_irq_before_done", {31'd0, irq_l}, 32'd0);
    tick(1);
    check("rd_irq_done", {31'd0, irq_l}, 32'd1);
    cpu_rd(2'd0, rv);
    check("rd_status", rv, 32'h00000002);
    cpu_wr(2'd2, 32'd0);
    for (int i = 0; i < 512; i++) exp_q.push_back({24'd0, m_buf[i]});
    for (int i = 0; i < 512; i++) begin
      cpu_rd(2'd3, rv);
      e = exp_q.pop_front();
      check($sformatf("rd_data[%0d]", i), rv, e);
    end
    m_last = 8'h00;

    // SD write: CPU fills with 0xA5, clear+start in one write, controller reads it back.
    for (int i = 0; i < 512; i++) begin
      r = $urandom;
      cpu_wr(2'd3, {r[31:8], 8'hA5});
      m_buf[i] = 8'hA5;
    end
    cpu_wr(2'd0, 32'h102);
    check("wr_issue_ctrl", {24'd0, ctrl_l}, 32'd2);
    check("wr_irq_cleared", {31'd0, irq_l}, 32'd0);
    sd_req = 1'b1; sd_wr_nrd = 1'b0;
    for (int i = 0; i < 512; i++) begin
      r = $urandom;
      sd_addr_in = {r[31:9], 9'(i)};
      tick(1);
      check($sformatf("wr_sd_data[%0d]", i), {24'd0, sddata_l}, {24'd0, m_buf[i]});
    end
    sd_req = 1'b0;

    // Drain: controller not yet idle for 10 cycles after completion.
    sd_state_in = 8'h02;
    pulse_done(8'h5A);
    m_last = 8'h5A;
    check("drain_ctrl_drop", {24'd0, ctrl_l}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      cpu_rd(2'd0, rv);
      check("drain_status_busy", rv, {16'd0, m_last, 8'h01});
      check("drain_ctrl_zero", {24'd0, ctrl_l}, 32'd0);
    end
    check("drain_irq_low", {31'd0, irq_l}, 32'd0);
    sd_state_in = 8'h01;
    tick(1);
    check("drain_irq_done", {31'd0, irq_l}, 32'd1);
    cpu_rd(2'd0, rv);
    check("drain_status_done", rv, {16'd0, m_last, 8'h02});

    // Busy rejection and CPU buffer lockout during an operation.
    cpu_wr(2'd2, 32'd7);
    cpu_wr(2'd0, 32'h100);
    cpu_wr(2'd0, 32'h1);
    tick(2);
    cpu_wr(2'd0, 32'h2);
    check("busy_ctrl_kept", {24'd0, ctrl_l}, 32'd1);
    cpu_rd(2'd0, rv);
    check("busy_status", rv, {16'd0, m_last, 8'h05});
    cpu_rd(2'd2, rv);
    check("busy_ptr_rd", rv, 32'd0);
    cpu_wr(2'd3, 32'hEE);
    cpu_rd(2'd3, rv);
    check("busy_data_rd", rv, 32'd0);
    cpu_wr(2'd1, 32'h77);
    check("busy_sector_kept", sdaddr_l, 32'd5);
    check("busy_irq", {31'd0, irq_l}, 32'd1);
    pulse_done(8'h11);
    m_last = 8'h11;
    tick(2);
    cpu_rd(2'd0, rv);
    check("busy_status_end", rv, {16'd0, m_last, 8'h06});
    cpu_wr(2'd0, 32'h100);
    check("clear_irq", {31'd0, irq_l}, 32'd0);
    cpu_rd(2'd0, rv);
    check("clear_status", rv, {16'd0, m_last, 8'h00});
    cpu_rd(2'd2, rv);
    check("busy_ptr_kept", rv, 32'd7);
    cpu_rd(2'd3, rv);
    check("busy_no_buf_write", rv, {24'd0, m_buf[7]});
    cpu_rd(2'd1, rv);
    check("sector_kept", rv, 32'd5);

    // Completion pulse while idle must not touch LAST_STATUS.
    pulse_done(8'h99);
    cpu_rd(2'd0, rv);
    check("idle_done_ignored", rv, {16'd0, m_last, 8'h00});

    // Pointer wrap.
    cpu_wr(2'd2, 32'd511);
    cpu_wr(2'd3, 32'h3C);
    m_buf[511] = 8'h3C;
    cpu_rd(2'd2, rv);
    check("wrap_ptr_wr", rv, 32'd0);
    cpu_wr(2'd2, 32'd511);
    cpu_rd(2'd3, rv);
    check("wrap_buf511", rv, 32'h3C);
    cpu_rd(2'd2, rv);
    check("wrap_ptr_rd", rv, 32'd0);

    // Random idle register traffic against the model.
    m_sector = 32'd5; m_ptr = 9'd0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0: begin cpu_wr(2'd1, r); m_sector = r; end
        1: begin cpu_rd(2'd1, rv); check("rnd_sector", rv, m_sector); end
        2: begin cpu_wr(2'd2, r); m_ptr = r[8:0]; end
        3: begin cpu_rd(2'd2, rv); check("rnd_ptr", rv, {23'd0, m_ptr}); end
        4: begin cpu_wr(2'd3, r); m_buf[m_ptr] = r[7:0]; m_ptr = m_ptr + 9'd1; end
        5, 6: begin
          cpu_rd(2'd3, rv);
          check("rnd_data", rv, {24'd0, m_buf[m_ptr]});
          m_ptr = m_ptr + 9'd1;
        end
        default: begin
          cpu_wr(2'd0, {r[31:2], r[0], r[0]});
          cpu_rd(2'd0, rv);
          check("rnd_status", rv, {16'd0, m_last, 8'h00});
        end
      endcase
    end

    // Timeout on the short-timeout instance; the long one stays waiting.
    apply_reset();
    sd_state_in = 8'h02;
    cpu_acc(1'b1, 2'd0, 32'h1, 1'b1, rv);
    tick(16);
    check("tmo_ctrl_before", {24'd0, ctrl_t}, 32'd1);
    check("tmo_irq_before", {31'd0, irq_t}, 32'd0);
    tick(1);
    check("tmo_ctrl_drop", {24'd0, ctrl_t}, 32'd0);
    check("tmo_irq", {31'd0, irq_t}, 32'd1);
    cpu_acc(1'b0, 2'd0, 32'd0, 1'b1, rv);
    check("tmo_status_drain", rv, 32'h00000009);
    sd_state_in = 8'h01;
    tick(1);
    cpu_acc(1'b0, 2'd0, 32'd0, 1'b1, rv);
    check("tmo_status_done", rv, 32'h0000000A);

    // Reset in the middle of an outstanding operation.
    check("midop_ctrl", {24'd0, ctrl_l}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midop_rst_ctrl", {24'd0, ctrl_l}, 32'd0);
    check("midop_rst_irq", {31'd0, irq_l}, 32'd0);
    cpu_rd(2'd0, rv);
    check("midop_rst_status", rv, 32'd0);
    cpu_rd(2'd1, rv);
    check("midop_rst_sector", rv, 32'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
